vector_issue_sequencer: RTL and testbench

VECTOR_ISSUE_SEQUENCER -- requirements
Module: vector_issue_sequencer

---
 rtl/vec_pkg.sv | 78 +++++++
 rtl/vec_scoreboard.sv | 38 +++
 rtl/vector_issue_sequencer.sv | 178 +++++++++++++++++
 tb/tb_vector_issue_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_pkg.sv
// Shared definitions for the vector issue sequencer: opcodes, functional-unit
// classes, default unit latencies and the opcode classifier.
package vec_pkg;

  localparam int NUM_VREGS = 32;

  // Load/store
  localparam logic [4:0] OP_VLOAD  = 5'b00000;
  localparam logic [4:0] OP_VSTORE = 5'b00001;
  // Integer add/sub (vector and scalar forms)
  localparam logic [4:0] OP_VADD   = 5'b00010;
  localparam logic [4:0] OP_VSUB   = 5'b00011;
  localparam logic [4:0] OP_VSADD  = 5'b00110;
  // Integer multiply
  localparam logic [4:0] OP_VMUL   = 5'b00100;
  localparam logic [4:0] OP_VSMUL  = 5'b00101;
  // Floating point
  localparam logic [4:0] OP_VFADD  = 5'b00111;
  localparam logic [4:0] OP_VFSUB  = 5'b10000;
  localparam logic [4:0] OP_VFMUL  = 5'b01000;
  localparam logic [4:0] OP_VSFADD = 5'b10101;
  localparam logic [4:0] OP_VSFMUL = 5'b10110;
  // Bitwise
  localparam logic [4:0] OP_VAND   = 5'b01001;
  localparam logic [4:0] OP_VOR    = 5'b01010;
  localparam logic [4:0] OP_VXOR   = 5'b01011;
  // Predicate set/compare
  localparam logic [4:0] OP_VPSET  = 5'b01100;
  localparam logic [4:0] OP_VCMPEQ = 5'b01101;
  localparam logic [4:0] OP_VCMPNE = 5'b01110;
  localparam logic [4:0] OP_VCMPLT = 5'b01111;
  localparam logic [4:0] OP_VCMPLE = 5'b11000;
  localparam logic [4:0] OP_VCMPGT = 5'b10001;
  localparam logic [4:0] OP_VCMPGE = 5'b10010;
  localparam logic [4:0] OP_VPCLR  = 5'b10100;
  localparam logic [4:0] OP_VPNOT  = 5'b10111;

  // Encoding doubles as the index of the unit's occupancy bit.
  typedef enum logic [2:0] {
    FU_LS      = 3'd0,
    FU_INT     = 3'd1,
    FU_MUL     = 3'd2,
    FU_FP      = 3'd3,
    FU_BIT     = 3'd4,
    FU_PRED    = 3'd5,
    FU_ILLEGAL = 3'd6
  } fu_class_e;

  localparam int DEF_LAT_INT  = 1;
  localparam int DEF_LAT_MUL  = 3;
  localparam int DEF_LAT_FP   = 4;
  localparam int DEF_LAT_BIT  = 1;
  localparam int DEF_LAT_PRED = 1;

  function automatic fu_class_e classify(input logic [4:0] op);
    case (op)
      OP_VLOAD, OP_VSTORE:                          return FU_LS;
      OP_VADD, OP_VSUB, OP_VSADD:                   return FU_INT;
      OP_VMUL, OP_VSMUL:                            return FU_MUL;
      OP_VFADD, OP_VFSUB, OP_VFMUL,
      OP_VSFADD, OP_VSFMUL:                         return FU_FP;
      OP_VAND, OP_VOR, OP_VXOR:                     return FU_BIT;
      OP_VPSET, OP_VCMPEQ, OP_VCMPNE, OP_VCMPLT,
      OP_VCMPLE, OP_VCMPGT, OP_VCMPGE, OP_VPCLR,
      OP_VPNOT:                                     return FU_PRED;
      default:                                      return FU_ILLEGAL;
    endcase
  endfunction

  // True for instructions whose [25:21] field names a vector register written.
  function automatic logic writes_vreg(input logic [4:0] op);
    fu_class_e c;
    c = classify(op);
    return (op == OP_VLOAD) || (c == FU_INT) || (c == FU_MUL) ||
           (c == FU_FP) || (c == FU_BIT);
  endfunction

endpackage

// File: rtl/vec_scoreboard.sv
// Busy bit per vector register: set on issue, cleared on completion, with
// three combinational lookups for hazard detection.
module vec_scoreboard
  import vec_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 set_en,
  input  logic [4:0]           set_idx,
  input  logic [NUM_VREGS-1:0] clr_mask,
  input  logic [4:0]           src1_idx,
  input  logic [4:0]           src2_idx,
  input  logic [4:0]           dest_idx,
  output logic                 src1_busy,
  output logic                 src2_busy,
  output logic                 dest_busy
);

  logic [NUM_VREGS-1:0] busy_q;
  logic [NUM_VREGS-1:0] set_vec;

  assign set_vec   = set_en ? (NUM_VREGS'(1) << set_idx) : '0;
  assign src1_busy = busy_q[src1_idx];
  assign src2_busy = busy_q[src2_idx];
  assign dest_busy = busy_q[dest_idx];

  // Update busy bits; the set term is applied after the clear so an issue
  // targeting a register that completes in the same cycle keeps it busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values; blocking here would race other always_ff readers.
      busy_q <= (busy_q & ~clr_mask) | set_vec;
    end
  end

endmodule

// File: rtl/vector_issue_sequencer.sv
// In-order single-issue sequencer: one-entry hold register, RAW/WAW/structural
// hazard checks against a register scoreboard, per-class latency counters and
// a flush/drain sequence.
module vector_issue_sequencer
  import vec_pkg::*;
#(
  parameter int LAT_INT  = DEF_LAT_INT,
  parameter int LAT_MUL  = DEF_LAT_MUL,
  parameter int LAT_FP   = DEF_LAT_FP,
  parameter int LAT_BIT  = DEF_LAT_BIT,
  parameter int LAT_PRED = DEF_LAT_PRED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_in,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [31:0] issue_instr,
  output logic        issue_valid,
  input  logic        mem_done,
  input  logic        flush,
  output logic        drained,
  output logic [31:0] wb_mask,
  output logic        illegal,
  output logic        busy
);

  typedef enum logic [1:0] {RUN, HOLD, DRAIN} state_e;

  // Counter reload values indexed by fu_class_e encoding (INT..PRED).
  localparam logic [7:0] LAT_TAB [1:5] = '{8'(LAT_INT), 8'(LAT_MUL), 8'(LAT_FP),
                                           8'(LAT_BIT), 8'(LAT_PRED)};

  state_e      state, state_nxt;
  logic        run_en, flush_pend, hold_valid;
  logic [31:0] hold_instr;
  logic        ls_busy, ls_wr;
  logic [4:0]  ls_dest;
  logic [7:0]  cnt       [1:5];
  logic [4:0]  unit_dest [1:5];
  logic        unit_wr   [1:5];

  logic [4:0]  op, dst, src1, src2;
  fu_class_e   hold_cls;
  logic        hold_wr, src1_busy, src2_busy, dest_busy;
  logic        raw_hz, waw_hz, struct_hz, hazard;
  logic        illegal_now, accept, flush_req, hold_leaving;
  logic [7:0]  unit_active;
  logic [31:0] done_mask;

  assign op       = hold_instr[31:27];
  assign dst      = hold_instr[25:21];
  assign src1     = hold_instr[20:16];
  assign src2     = hold_instr[15:11];
  assign hold_cls = classify(op);
  assign hold_wr  = writes_vreg(op);

  vec_scoreboard u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (issue_valid && hold_wr),
    .set_idx   (dst),
    .clr_mask  (done_mask),
    .src1_idx  (src1),
    .src2_idx  (src2),
    .dest_idx  (dst),
    .src1_busy (src1_busy),
    .src2_busy (src2_busy),
    .dest_busy (dest_busy)
  );

  // Unit occupancy and this cycle's completions (counter at 1 finishes now).
  always_comb begin
    // NOTE: defaults first so every path assigns every bit; otherwise synthesis infers latches.
    unit_active    = '0;
    done_mask      = '0;
    unit_active[0] = ls_busy;
    if (ls_busy && mem_done && ls_wr) done_mask[ls_dest] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      unit_active[i] = (cnt[i] != 8'd0);
      if (cnt[i] == 8'd1 && unit_wr[i]) done_mask[unit_dest[i]] = 1'b1;
    end
  end

  // VSTORE reads the register named in its dest field, so it is a RAW source.
  assign raw_hz       = src1_busy || src2_busy || (op == OP_VSTORE && dest_busy);
  assign waw_hz       = hold_wr && dest_busy;
  assign struct_hz    = unit_active[hold_cls];
  assign hazard       = raw_hz || waw_hz || struct_hz;
  assign illegal_now  = hold_valid && (hold_cls == FU_ILLEGAL);

  assign issue_valid  = hold_valid && !illegal_now && !hazard;
  assign issue_instr  = hold_instr;
  assign instr_ready  = run_en && (state == RUN) && (!hold_valid || issue_valid);
  assign accept       = instr_valid && instr_ready;
  assign illegal      = illegal_now;
  assign wb_mask      = done_mask;
  assign busy         = hold_valid || (|unit_active);
  assign flush_req    = flush || flush_pend;
  assign hold_leaving = !hold_valid || issue_valid || illegal_now;

  // Next-state logic; drained pulses on the DRAIN->RUN transition.
  always_comb begin
    state_nxt = state;
    drained   = 1'b0;
    case (state)
      RUN: begin
        if (flush_req && hold_leaving)      state_nxt = DRAIN;
        else if (hold_valid && hazard && !illegal_now) state_nxt = HOLD;
      end
      HOLD: begin
        if (issue_valid) state_nxt = flush_req ? DRAIN : RUN;
      end
      DRAIN: begin
        if (!(|unit_active) && !hold_valid) begin
          state_nxt = RUN;
          drained   = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Control state, pending flush and the hold register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      run_en     <= 1'b0;
      flush_pend <= 1'b0;
      hold_valid <= 1'b0;
      hold_instr <= '0;
    end else begin
      state  <= state_nxt;
      run_en <= 1'b1;
      if (state_nxt == DRAIN)               flush_pend <= 1'b0;
      else if (flush && state != DRAIN)     flush_pend <= 1'b1;
      if (accept) begin
        hold_valid <= 1'b1;
        hold_instr <= instr_in;
      end else if (issue_valid || illegal_now) begin
        hold_valid <= 1'b0;
      end
    end
  end

  // Functional-unit tracking: LS waits for mem_done, others count down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ls_busy <= 1'b0;
      ls_wr   <= 1'b0;
      ls_dest <= '0;
      // NOTE: these small register arrays are reset so a reset mid-operation abandons in-flight work.
      for (int i = 1; i <= 5; i++) begin
        cnt[i]       <= '0;
        unit_dest[i] <= '0;
        unit_wr[i]   <= 1'b0;
      end
    end else begin
      if (issue_valid && hold_cls == FU_LS) begin
        ls_busy <= 1'b1;
        ls_wr   <= hold_wr;
        ls_dest <= dst;
      end else if (ls_busy && mem_done) begin
        ls_busy <= 1'b0;
      end
      for (int i = 1; i <= 5; i++) begin
        if (issue_valid && int'(hold_cls) == i) begin
          cnt[i]       <= LAT_TAB[i];
          unit_dest[i] <= dst;
          unit_wr[i]   <= hold_wr;
        end else if (cnt[i] != 8'd0) begin
          cnt[i] <= cnt[i] - 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_issue_sequencer.sv
// Directed bench for vector_issue_sequencer with hand-computed expectations.
module tb_vector_issue_sequencer;
  import vec_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] issue_instr;
  logic        issue_valid;
  logic        mem_done;
  logic        flush;
  logic        drained;
  logic [31:0] wb_mask;
  logic        illegal;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vector_issue_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .issue_instr (issue_instr),
    .issue_valid (issue_valid),
    .mem_done    (mem_done),
    .flush       (flush),
    .drained     (drained),
    .wb_mask     (wb_mask),
    .illegal     (illegal),
    .busy        (busy)
  );

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] d,
                                     input logic [4:0] s1, input logic [4:0] s2);
    return {op, 1'b0, d, s1, s2, 11'd0};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle(input int n);
    instr_valid = 1'b0;
    mem_done    = 1'b0;
    flush       = 1'b0;
    repeat (n) next_cycle();
  endtask

  task automatic test_reset();
    #7;
    checks++;
    if ({instr_ready, issue_valid, drained, illegal, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs: rdy/iv/drn/ill/busy=%b expected 00000",
               {instr_ready, issue_valid, drained, illegal, busy});
    end
    checks++;
    if ({wb_mask, issue_instr} !== 64'd0) begin
      failures++;
      $display("FAIL reset_vectors: wb_mask=%h issue_instr=%h expected 0/0", wb_mask, issue_instr);
    end
    #5 rst_n = 1'b1;
    next_cycle();
    checks++;
    if ({instr_ready, busy} !== 2'b10) begin
      failures++;
      $display("FAIL reset_release: ready/busy=%b expected 10", {instr_ready, busy});
    end
  endtask

  task automatic test_raw();
    next_cycle();
    instr_in = mk(OP_VADD, 5'd3, 5'd1, 5'd2); instr_valid = 1'b1; settle();
    checks++;
    if (instr_ready !== 1'b1) begin
      failures++; $display("FAIL raw_accept: instr_ready=%b expected 1", instr_ready);
    end
    next_cycle();
    instr_in = mk(OP_VADD, 5'd4, 5'd3, 5'd5); settle();
    checks++;
    if ({issue_valid, instr_ready, issue_instr} !== {2'b11, mk(OP_VADD, 5'd3, 5'd1, 5'd2)}) begin
      failures++;
      $display("FAIL raw_issue1: iv/rdy=%b instr=%h expected 11 %h",
               {issue_valid, instr_ready}, issue_instr, mk(OP_VADD, 5'd3, 5'd1, 5'd2));
    end
    next_cycle();
    instr_valid = 1'b0; settle();
    checks++;
    if ({issue_valid, wb_mask} !== {1'b0, 32'h0000_0008}) begin
      failures++; $display("FAIL raw_stall_wb3: iv=%b wb=%h expected 0 00000008", issue_valid, wb_mask);
    end
    next_cycle(); settle();
    checks++;
    if ({issue_valid, issue_instr, wb_mask} !== {1'b1, mk(OP_VADD, 5'd4, 5'd3, 5'd5), 32'd0}) begin
      failures++; $display("FAIL raw_issue2: iv=%b instr=%h wb=%h", issue_valid, issue_instr, wb_mask);
    end
    next_cycle(); settle();
    checks++;
    if (wb_mask !== 32'h0000_0010) begin
      failures++; $display("FAIL raw_wb4: wb=%h expected 00000010", wb_mask);
    end
    idle(3);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL raw_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_structural();
    next_cycle();
    instr_in = mk(OP_VMUL, 5'd1, 5'd10, 5'd11); instr_valid = 1'b1; settle();
    next_cycle();
    instr_in = mk(OP_VADD, 5'd6, 5'd12, 5'd13); settle();
    checks++;
    if ({issue_valid, issue_instr} !== {1'b1, mk(OP_VMUL, 5'd1, 5'd10, 5'd11)}) begin
      failures++; $display("FAIL mul_issue1: iv=%b instr=%h", issue_valid, issue_instr);
    end
    next_cycle();
    instr_in = mk(OP_VMUL, 5'd2, 5'd14, 5'd15); settle();
    checks++;
    if ({issue_valid, issue_instr} !== {1'b1, mk(OP_VADD, 5'd6, 5'd12, 5'd13)}) begin
      failures++; $display("FAIL mul_vadd_between: iv=%b instr=%h", issue_valid, issue_instr);
    end
    next_cycle();
    instr_valid = 1'b0; settle();
    checks++;
    if ({issue_valid, wb_mask} !== {1'b0, 32'h0000_0040}) begin
      failures++; $display("FAIL mul_stall_a: iv=%b wb=%h expected 0 00000040", issue_valid, wb_mask);
    end
    next_cycle(); settle();
    checks++;
    if ({issue_valid, wb_mask} !== {1'b0, 32'h0000_0002}) begin
      failures++; $display("FAIL mul_stall_b: iv=%b wb=%h expected 0 00000002", issue_valid, wb_mask);
    end
    next_cycle(); settle();
    checks++;
    if ({issue_valid, issue_instr} !== {1'b1, mk(OP_VMUL, 5'd2, 5'd14, 5'd15)}) begin
      failures++; $display("FAIL mul_issue2: iv=%b instr=%h", issue_valid, issue_instr);
    end
    repeat (3) next_cycle();
    settle();
    checks++;
    if (wb_mask !== 32'h0000_0004) begin
      failures++; $display("FAIL mul_wb2: wb=%h expected 00000004", wb_mask);
    end
  endtask

  task automatic test_load_store();
    next_cycle();
    instr_in = mk(OP_VLOAD, 5'd7, 5'd20, 5'd0); instr_valid = 1'b1; settle();
    next_cycle();
    instr_in = mk(OP_VSTORE, 5'd7, 5'd21, 5'd0); settle();
    checks++;
    if ({issue_valid, issue_instr} !== {1'b1, mk(OP_VLOAD, 5'd7, 5'd20, 5'd0)}) begin
      failures++; $display("FAIL ls_load_issue: iv=%b instr=%h", issue_valid, issue_instr);
    end
    next_cycle();
    instr_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      checks++;
      if ({issue_valid, wb_mask, busy} !== {1'b0, 32'd0, 1'b1}) begin
        failures++;
        $display("FAIL ls_store_wait: cycle %0d iv=%b wb=%h busy=%b expected 0 0 1",
                 i, issue_valid, wb_mask, busy);
      end
      next_cycle();
    end
    mem_done = 1'b1; settle();
    checks++;
    if ({issue_valid, wb_mask} !== {1'b0, 32'h0000_0080}) begin
      failures++; $display("FAIL ls_load_done: iv=%b wb=%h expected 0 00000080", issue_valid, wb_mask);
    end
    next_cycle();
    mem_done = 1'b0; settle();
    checks++;
    if ({issue_valid, issue_instr} !== {1'b1, mk(OP_VSTORE, 5'd7, 5'd21, 5'd0)}) begin
      failures++; $display("FAIL ls_store_issue: iv=%b instr=%h", issue_valid, issue_instr);
    end
    next_cycle();
    mem_done = 1'b1; settle();
    checks++;
    if ({wb_mask, busy} !== {32'd0, 1'b1}) begin
      failures++; $display("FAIL ls_store_done: wb=%h busy=%b expected 0 1", wb_mask, busy);
    end
    next_cycle(); settle();
    checks++;
    if ({wb_mask, busy} !== {32'd0, 1'b0}) begin
      failures++; $display("FAIL ls_stray_mem_done: wb=%h busy=%b expected 0 0", wb_mask, busy);
    end
    mem_done = 1'b0;
  endtask

  task automatic test_simultaneous_wb();
    next_cycle();
    instr_in = mk(OP_VFMUL, 5'd8, 5'd1, 5'd2); instr_valid = 1'b1; settle();
    next_cycle();
    instr_valid = 1'b0; settle();
    checks++;
    if ({issue_valid, issue_instr} !== {1'b1, mk(OP_VFMUL, 5'd8, 5'd1, 5'd2)}) begin
      failures++; $display("FAIL simul_fmul_issue: iv=%b instr=%h", issue_valid, issue_instr);
    end
    next_cycle();
    next_cycle();
    instr_in = mk(OP_VADD, 5'd9, 5'd3, 5'd4); instr_valid = 1'b1; settle();
    next_cycle();
    instr_valid = 1'b0; settle();
    checks++;
    if ({issue_valid, wb_mask} !== {1'b1, 32'd0}) begin
      failures++; $display("FAIL simul_vadd_issue: iv=%b wb=%h expected 1 0", issue_valid, wb_mask);
    end
    next_cycle(); settle();
    checks++;
    if (wb_mask !== 32'h0000_0300) begin
      failures++; $display("FAIL simul_wb: wb=%h expected 00000300", wb_mask);
    end
    next_cycle(); settle();
    checks++;
    if (wb_mask !== 32'd0) begin
      failures++; $display("FAIL simul_wb_after: wb=%h expected 0", wb_mask);
    end
  endtask

  task automatic test_illegal();
    next_cycle();
    instr_in = mk(5'b11111, 5'd5, 5'd1, 5'd2); instr_valid = 1'b1; settle();
    next_cycle();
    instr_valid = 1'b0; settle();
    checks++;
    if ({illegal, issue_valid, instr_ready} !== 3'b100) begin
      failures++; $display("FAIL illegal_pulse: ill/iv/rdy=%b expected 100", {illegal, issue_valid, instr_ready});
    end
    next_cycle();
    instr_in = mk(OP_VAND, 5'd5, 5'd1, 5'd2); instr_valid = 1'b1; settle();
    checks++;
    if ({illegal, issue_valid, instr_ready} !== 3'b001) begin
      failures++; $display("FAIL illegal_dropped: ill/iv/rdy=%b expected 001", {illegal, issue_valid, instr_ready});
    end
    next_cycle();
    instr_valid = 1'b0; settle();
    checks++;
    if ({illegal, issue_valid, issue_instr} !== {2'b01, mk(OP_VAND, 5'd5, 5'd1, 5'd2)}) begin
      failures++; $display("FAIL illegal_next_issue: ill/iv=%b instr=%h", {illegal, issue_valid}, issue_instr);
    end
    next_cycle(); settle();
    checks++;
    if (wb_mask !== 32'h0000_0020) begin
      failures++; $display("FAIL illegal_next_wb: wb=%h expected 00000020", wb_mask);
    end
  endtask

  task automatic test_pred();
    next_cycle();
    instr_in = mk(OP_VCMPEQ, 5'd3, 5'd1, 5'd2); instr_valid = 1'b1; settle();
    next_cycle();
    instr_in = mk(OP_VADD, 5'd4, 5'd3, 5'd3); settle();
    next_cycle();
    instr_valid = 1'b0; settle();
    checks++;
    if ({issue_valid, issue_instr, wb_mask} !== {1'b1, mk(OP_VADD, 5'd4, 5'd3, 5'd3), 32'd0}) begin
      failures++; $display("FAIL pred_no_scoreboard: iv=%b instr=%h wb=%h", issue_valid, issue_instr, wb_mask);
    end
  endtask

  task automatic test_flush();
    next_cycle();
    instr_in = mk(OP_VMUL, 5'd10, 5'd1, 5'd2); instr_valid = 1'b1; settle();
    next_cycle();
    instr_valid = 1'b0; settle();
    checks++;
    if (issue_valid !== 1'b1) begin
      failures++; $display("FAIL flush_mul_issue: iv=%b expected 1", issue_valid);
    end
    next_cycle();
    flush = 1'b1; settle();
    next_cycle();
    flush = 1'b0; instr_in = mk(OP_VADD, 5'd11, 5'd1, 5'd2); instr_valid = 1'b1; settle();
    checks++;
    if ({instr_ready, drained} !== 2'b00) begin
      failures++; $display("FAIL flush_drain_a: rdy/drn=%b expected 00", {instr_ready, drained});
    end
    next_cycle();
    flush = 1'b1; settle();
    checks++;
    if ({instr_ready, drained, wb_mask} !== {2'b00, 32'h0000_0400}) begin
      failures++; $display("FAIL flush_drain_b: rdy/drn=%b wb=%h", {instr_ready, drained}, wb_mask);
    end
    next_cycle();
    flush = 1'b0; settle();
    checks++;
    if ({instr_ready, drained} !== 2'b01) begin
      failures++; $display("FAIL flush_drained: rdy/drn=%b expected 01", {instr_ready, drained});
    end
    next_cycle();
    instr_valid = 1'b0; settle();
    checks++;
    if ({instr_ready, drained, busy} !== 3'b100) begin
      failures++; $display("FAIL flush_run: rdy/drn/busy=%b expected 100", {instr_ready, drained, busy});
    end
    next_cycle(); settle();
    checks++;
    if ({instr_ready, issue_valid, busy} !== 3'b100) begin
      failures++; $display("FAIL flush_no_accept: rdy/iv/busy=%b expected 100", {instr_ready, issue_valid, busy});
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] seen;
    next_cycle();
    instr_in = mk(OP_VFADD, 5'd12, 5'd1, 5'd2); instr_valid = 1'b1; settle();
    next_cycle();
    instr_valid = 1'b0; settle();
    next_cycle(); settle();
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL rstmid_busy: busy=%b expected 1", busy);
    end
    rst_n = 1'b0; settle();
    checks++;
    if ({busy, instr_ready, wb_mask} !== 34'd0) begin
      failures++; $display("FAIL rstmid_clear: busy/rdy=%b wb=%h expected 00 0", {busy, instr_ready}, wb_mask);
    end
    next_cycle();
    rst_n = 1'b1;
    seen = '0;
    for (int i = 0; i < 6; i++) begin
      settle();
      seen |= wb_mask;
      next_cycle();
    end
    checks++;
    if ({seen, instr_ready, busy} !== {32'd0, 2'b10}) begin
      failures++; $display("FAIL rstmid_no_wb: seen_wb=%h rdy/busy=%b expected 0 10", seen, {instr_ready, busy});
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_in    = '0;
    instr_valid = 1'b0;
    mem_done    = 1'b0;
    flush       = 1'b0;
    test_reset();
    test_raw();
    idle(2);
    test_structural();
    idle(3);
    test_load_store();
    idle(2);
    test_simultaneous_wb();
    idle(2);
    test_illegal();
    idle(2);
    test_pred();
    idle(3);
    test_flush();
    idle(2);
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
